ext_com_ack_transmitter: RTL and testbench



---
 rtl/ext_com_ack_transmitter.sv | 165 ++++++++++++++++
 tb/tb_ext_com_ack_transmitter.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ext_com_ack_transmitter.sv
// UART byte transmitter with ACK reception, timeout and bounded retransmission.
module ext_com_ack_transmitter #(
  parameter int unsigned     UART_WIDTH            = 8,
  parameter int unsigned     CLK_FREQ              = 50_000_000,
  parameter int unsigned     UART_BAUD_RATE        = 230400,
  parameter int unsigned     UART_RETRANSMIT_COUNT = 5,
  parameter logic [UART_WIDTH-1:0] UART_ACK        = 8'b11001100,
  parameter int unsigned     ACK_TIMEOUT_BITS      = 40
) (
  input  logic                  clk,
  input  logic                  rstN,
  input  logic [UART_WIDTH-1:0] din,
  input  logic                  send,
  output logic                  ready,
  output logic                  tx,
  input  logic                  rx,
  output logic                  done,
  output logic                  fail,
  output logic [2:0]            attempt
);

  localparam int unsigned CLKS_PER_BIT = CLK_FREQ / UART_BAUD_RATE;
  localparam int unsigned HALF_BIT     = CLKS_PER_BIT / 2;
  localparam int unsigned TO_LOAD      = ACK_TIMEOUT_BITS * CLKS_PER_BIT;
  localparam int unsigned BAUD_W       = $clog2(CLKS_PER_BIT);
  localparam int unsigned BIT_W        = $clog2(UART_WIDTH + 1);
  localparam int unsigned TO_W         = $clog2(TO_LOAD + 1);
  localparam int unsigned ATT_W        = 3;

  typedef enum logic [3:0] {
    S_IDLE, S_TX_START, S_TX_DATA, S_TX_STOP, S_WAIT_ACK,
    S_RX_START, S_RX_DATA, S_RX_STOP, S_RETRY, S_DONE, S_FAIL
  } state_t;

  state_t                state, next_state;
  logic [BAUD_W-1:0]     baud_cnt;
  logic [BIT_W-1:0]      bit_cnt;
  logic [TO_W-1:0]       to_cnt;
  logic [UART_WIDTH-1:0] data_q, tx_sr, rx_sr;
  logic                  rx_meta, rx_s, rx_s_q;
  logic                  tx_d, ready_d, done_d, fail_d;
  logic [ATT_W-1:0]      attempt_d;

  logic baud_end, half_end, last_bit, to_zero, rx_fall, can_retry, in_listen;
  assign baud_end  = (baud_cnt == BAUD_W'(CLKS_PER_BIT - 1));
  assign half_end  = (baud_cnt == BAUD_W'(HALF_BIT - 1));
  assign last_bit  = (bit_cnt == BIT_W'(UART_WIDTH - 1));
  assign to_zero   = (to_cnt == '0);
  assign rx_fall   = rx_s_q & ~rx_s;
  assign can_retry = (attempt < ATT_W'(UART_RETRANSMIT_COUNT));
  assign in_listen = (state == S_WAIT_ACK) || (state == S_RX_START) ||
                     (state == S_RX_DATA)  || (state == S_RX_STOP);

  // State register
  always_ff @(posedge clk) begin
    if (!rstN) state <= S_IDLE;
    else       state <= next_state;
  end

  // Next-state decode
  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:     if (send) next_state = S_TX_START;
      S_TX_START: if (baud_end) next_state = S_TX_DATA;
      S_TX_DATA:  if (baud_end && last_bit) next_state = S_TX_STOP;
      S_TX_STOP:  if (baud_end) next_state = S_WAIT_ACK;
      S_WAIT_ACK: begin
        if (rx_fall)      next_state = S_RX_START;
        else if (to_zero) next_state = S_RETRY;
      end
      // Glitch rejection: a start bit must still be low at mid-bit
      S_RX_START: if (half_end) next_state = rx_s ? S_WAIT_ACK : S_RX_DATA;
      S_RX_DATA:  if (baud_end && last_bit) next_state = S_RX_STOP;
      S_RX_STOP: begin
        if (baud_end) begin
          if (rx_s && (rx_sr == UART_ACK)) next_state = S_DONE;
          else if (to_zero)                next_state = S_RETRY;
          else                             next_state = S_WAIT_ACK;
        end
      end
      S_RETRY:    next_state = can_retry ? S_TX_START : S_FAIL;
      S_DONE:     next_state = S_IDLE;
      S_FAIL:     next_state = S_IDLE;
      default:    next_state = S_IDLE;
    endcase
  end

  // Output decode from the upcoming state, registered below
  always_comb begin
    tx_d      = 1'b1;
    ready_d   = 1'b0;
    done_d    = 1'b0;
    fail_d    = 1'b0;
    attempt_d = attempt;
    case (next_state)
      S_IDLE:     ready_d = 1'b1;
      S_TX_START: tx_d = 1'b0;
      S_TX_DATA:  tx_d = (state == S_TX_DATA && baud_end) ? tx_sr[1] : tx_sr[0];
      S_DONE:     done_d = 1'b1;
      S_FAIL:     fail_d = 1'b1;
      default:    ;
    endcase
    if (next_state == S_IDLE)
      attempt_d = '0;
    else if (next_state == S_TX_START && state != S_TX_START)
      attempt_d = attempt + ATT_W'(1);
  end

  // Datapath: synchroniser, counters, shift registers and output registers
  always_ff @(posedge clk) begin
    if (!rstN) begin
      rx_meta  <= 1'b1;
      rx_s     <= 1'b1;
      rx_s_q   <= 1'b1;
      tx       <= 1'b1;
      ready    <= 1'b1;
      done     <= 1'b0;
      fail     <= 1'b0;
      attempt  <= '0;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      to_cnt   <= '0;
      data_q   <= '0;
      tx_sr    <= '0;
      rx_sr    <= '0;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
      rx_s_q  <= rx_s;
      tx      <= tx_d;
      ready   <= ready_d;
      done    <= done_d;
      fail    <= fail_d;
      attempt <= attempt_d;

      if (state == S_IDLE && send) begin
        data_q <= din;
        tx_sr  <= din;
      end else if (state == S_RETRY && next_state == S_TX_START) begin
        tx_sr <= data_q;
      end else if (state == S_TX_DATA && baud_end) begin
        tx_sr <= tx_sr >> 1;
      end

      if (next_state != state || baud_end) baud_cnt <= '0;
      else                                 baud_cnt <= baud_cnt + BAUD_W'(1);

      if (next_state != state)
        bit_cnt <= '0;
      else if ((state == S_TX_DATA || state == S_RX_DATA) && baud_end)
        bit_cnt <= bit_cnt + BIT_W'(1);

      if (state == S_RX_DATA && baud_end)
        rx_sr <= {rx_s, rx_sr[UART_WIDTH-1:1]};

      // Timeout keeps running through ACK reception; it saturates at zero
      if (state == S_TX_STOP && next_state == S_WAIT_ACK)
        to_cnt <= TO_W'(TO_LOAD);
      else if (in_listen && !to_zero)
        to_cnt <= to_cnt - TO_W'(1);
    end
  end

endmodule

// File: tb/tb_ext_com_ack_transmitter.sv
// Scoreboard bench for ext_com_ack_transmitter: frame and done/fail monitors.
module tb_ext_com_ack_transmitter;

  localparam int CPB   = 217;
  localparam int HALF  = 108;
  localparam int FRAME = 10 * CPB;
  // start+8 data+stop, 40 bit periods of WAIT_ACK plus its zero cycle, one RETRY cycle
  localparam int RETRY_GAP = FRAME + 40 * CPB + 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] din = 8'h00;
  logic       send = 1'b0;
  logic       rx = 1'b1;
  logic       ready, tx, done, fail;
  logic [2:0] attempt;

  ext_com_ack_transmitter dut (
    .clk(clk), .rstN(rst_n), .din(din), .send(send), .ready(ready),
    .tx(tx), .rx(rx), .done(done), .fail(fail), .attempt(attempt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    int         att;
    int         gap;
  } frame_t;

  frame_t exp_frames[$];
  int     exp_events[$];   // 1 = done, 2 = fail
  int     n_chk = 0;
  int     n_fail = 0;
  int     cyc = 0;
  int     rst_cnt = 0;
  bit     mon_busy = 1'b0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!rst_n) rst_cnt <= rst_cnt + 1;
  end

  function automatic void chk(string name, int act, int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  function automatic void push_frame(logic [7:0] d, int att, int gap);
    frame_t f;
    f.data = d;
    f.att  = att;
    f.gap  = gap;
    exp_frames.push_back(f);
  endfunction

  // Frame monitor: decode every tx frame at mid-bit and compare with the queue
  initial begin
    logic       tx_prev;
    logic [7:0] b;
    logic       sb, stb;
    int         st, last_st, r0, att_seen;
    bit         rdy_ok, att_ok;
    frame_t     e;
    tx_prev = 1'b1;
    last_st = -1;
    forever begin
      @(negedge clk);
      if (rst_n && tx_prev && !tx) begin
        mon_busy = 1'b1;
        st       = cyc;
        r0       = rst_cnt;
        att_seen = int'(attempt);
        rdy_ok   = 1'b1;
        att_ok   = 1'b1;
        repeat (HALF) @(negedge clk);
        sb = tx;
        for (int i = 0; i < 8; i++) begin
          repeat (CPB) @(negedge clk);
          b[i] = tx;
          if (ready) rdy_ok = 1'b0;
          if (int'(attempt) != att_seen) att_ok = 1'b0;
        end
        repeat (CPB) @(negedge clk);
        stb = tx;
        if (rst_cnt == r0) begin
          chk("frame_expected", int'(exp_frames.size() > 0), 1);
          if (exp_frames.size() > 0) begin
            e = exp_frames.pop_front();
            chk("frame_start_bit", int'(sb), 0);
            chk("frame_data", int'(b), int'(e.data));
            chk("frame_stop_bit", int'(stb), 1);
            chk("frame_attempt", att_seen, e.att);
            chk("frame_attempt_stable", int'(att_ok), 1);
            chk("frame_ready_low", int'(rdy_ok), 1);
            if (e.gap >= 0) chk("frame_gap", st - last_st, e.gap);
          end
        end
        last_st  = st;
        mon_busy = 1'b0;
      end
      tx_prev = tx;
    end
  end

  // Event monitor: done/fail pulses against the expected event queue
  initial begin
    int ev;
    forever begin
      @(negedge clk);
      if (rst_n && (done || fail)) begin
        chk("done_fail_exclusive", int'(done & fail), 0);
        ev = done ? 1 : 2;
        if (exp_events.size() == 0) chk("unexpected_event", ev, 0);
        else                        chk("event_kind", ev, exp_events.pop_front());
        @(negedge clk);
        chk("pulse_width", int'(done | fail), 0);
        chk("ready_after_event", int'(ready), 1);
        chk("attempt_after_event", int'(attempt), 0);
      end
    end
  end

  task automatic tick(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_send(logic [7:0] v);
    @(negedge clk);
    din  = v;
    send = 1'b1;
    @(negedge clk);
    send = 1'b0;
  endtask

  task automatic wait_tx_fall();
    int n = 0;
    while (tx !== 1'b0 && n < 2000) begin
      tick(1);
      n++;
    end
    chk("tx_frame_started", int'(tx), 0);
  endtask

  task automatic rx_byte(logic [7:0] v);
    rx = 1'b0;
    tick(CPB);
    for (int i = 0; i < 8; i++) begin
      rx = v[i];
      tick(CPB);
    end
    rx = 1'b1;
    tick(CPB);
  endtask

  task automatic wait_idle(int bound);
    int n = 0;
    while (!(ready === 1'b1 && exp_events.size() == 0 && exp_frames.size() == 0 && !mon_busy)
           && n < bound) begin
      tick(1);
      n++;
    end
    chk("idle_reached", int'(n < bound), 1);
  endtask

  // Directed stimulus
  initial begin
    bit tx_stayed_high;
    int n;

    tick(4);
    chk("rst_tx", int'(tx), 1);
    chk("rst_ready", int'(ready), 1);
    chk("rst_done", int'(done), 0);
    chk("rst_fail", int'(fail), 0);
    chk("rst_attempt", int'(attempt), 0);
    rst_n = 1'b1;
    tick(2);
    chk("idle_ready", int'(ready), 1);
    chk("idle_tx", int'(tx), 1);

    // Send 0x2A and acknowledge it
    push_frame(8'h2A, 1, -1);
    exp_events.push_back(1);
    do_send(8'h2A);
    chk("ready_low_after_send", int'(ready), 0);
    chk("attempt_one", int'(attempt), 1);
    wait_tx_fall();
    tick(FRAME + 20);
    rx_byte(8'hCC);
    wait_idle(3000);

    // Wrong byte first, then ACK before the timeout: no retransmission
    push_frame(8'h2A, 1, -1);
    exp_events.push_back(1);
    do_send(8'h2A);
    wait_tx_fall();
    tick(FRAME + 20);
    rx_byte(8'h55);
    tick(30);
    chk("wrong_byte_still_busy", int'(ready), 0);
    rx_byte(8'hCC);
    wait_idle(3000);
    tick(200);
    chk("no_retransmit_ready", int'(ready), 1);

    // No ACK: five frames at fixed spacing, a rejected rx glitch in the first wait
    push_frame(8'h2A, 1, -1);
    for (int a = 2; a <= 5; a++) push_frame(8'h2A, a, RETRY_GAP);
    exp_events.push_back(2);
    do_send(8'h2A);
    wait_tx_fall();
    tick(300);
    do_send(8'h00);
    chk("busy_send_ignored_attempt", int'(attempt), 1);
    tick(FRAME + 200);
    rx = 1'b0;
    tick(3);
    rx = 1'b1;
    wait_idle(60000);

    // Reset in the middle of TX_DATA, then a clean 0xFF transfer
    do_send(8'h2A);
    wait_tx_fall();
    tick(CPB * 4);
    rst_n = 1'b0;
    tick(1);
    rst_n = 1'b1;
    chk("midreset_tx", int'(tx), 1);
    chk("midreset_ready", int'(ready), 1);
    chk("midreset_attempt", int'(attempt), 0);
    tx_stayed_high = 1'b1;
    n = 0;
    while (mon_busy && n < 3000) begin
      tick(1);
      n++;
      if (tx !== 1'b1) tx_stayed_high = 1'b0;
    end
    chk("midreset_tx_stays_idle", int'(tx_stayed_high), 1);
    push_frame(8'hFF, 1, -1);
    exp_events.push_back(1);
    do_send(8'hFF);
    wait_tx_fall();
    tick(FRAME + 20);
    rx_byte(8'hCC);
    wait_idle(3000);

    chk("frames_drained", exp_frames.size(), 0);
    chk("events_drained", exp_events.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  // Global time bound
  initial begin
    #(95000 * 10);
    $display("FAIL watchdog: simulation exceeded 95000 cycles, got cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
